// File: rtl/common.sv
// Shared types and constants for the per-thread PC controller.
package common;

    localparam int n_threads = 4;

    typedef logic [31:0] vptr_t;
    typedef logic [$clog2(n_threads)-1:0] threadid_t;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } pc_state_t;

    localparam vptr_t RESET_PC   = 32'h0000_1000;
    localparam vptr_t EXC_VECTOR = 32'h0000_2000;

endpackage

// File: rtl/thread_pc_slot.sv
// One hardware thread's fetch PC, saved exception PC, privilege mode,
// redirect epoch and RUN/WAIT fetch state. Event inputs are already
// decoded for this thread by the parent.
module thread_pc_slot
    import common::*;
#(
    parameter vptr_t PC_INIT = RESET_PC,
    parameter vptr_t PC_TRAP = EXC_VECTOR
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  fetch_en,
    input  logic  fetch_miss,
    input  logic  refill_en,
    input  logic  br_en,
    input  vptr_t br_target,
    input  logic  exc_en,
    input  vptr_t exc_pc,
    input  logic  eret_en,
    output vptr_t pc,
    output vptr_t epc,
    output logic  mode,
    output logic  epoch,
    output logic  ready
);

    pc_state_t state_q;
    pc_state_t state_d;
    logic      redirect;

    assign redirect = exc_en | eret_en | br_en;

    // State register for the RUN/WAIT fetch machine
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: any redirect cancels a wait, a miss parks the thread, a refill resumes it
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = RUN;
        end else begin
            unique case (state_q)
                RUN:     if (fetch_en && fetch_miss) state_d = WAIT;
                WAIT:    if (refill_en) state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    // Thread may be scheduled only while it is not waiting on a refill
    always_comb begin
        ready = (state_q == RUN);
    end

    // PC, EPC, mode and epoch updates with priority exc > eret > br > sequential advance
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= PC_INIT;
            epc   <= '0;
            mode  <= 1'b1;
            epoch <= 1'b0;
        end else if (exc_en) begin
            pc    <= PC_TRAP;
            epc   <= exc_pc;
            mode  <= 1'b1;
            epoch <= ~epoch;
        end else if (eret_en) begin
            pc    <= epc;
            mode  <= 1'b0;
            epoch <= ~epoch;
        end else if (br_en) begin
            pc    <= br_target & ~vptr_t'(3);
            epoch <= ~epoch;
        end else if (fetch_en && !fetch_miss && state_q == RUN) begin
            pc    <= pc + vptr_t'(4);
        end
    end

endmodule

// File: rtl/thread_pc_ctrl.sv
// Per-thread program-counter controller feeding the fetch stage. Decodes
// the thread-addressed event buses into per-thread strobes and instantiates
// one thread_pc_slot per hardware thread.
module thread_pc_ctrl
    import common::*;
#(
    parameter int    N_THREADS  = common::n_threads,
    parameter vptr_t RESET_PC   = common::RESET_PC,
    parameter vptr_t EXC_VECTOR = common::EXC_VECTOR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_valid,
    input  threadid_t            fetch_thread,
    input  logic                 fetch_miss,
    input  logic                 refill_done,
    input  threadid_t            refill_thread,
    input  logic                 br_en,
    input  threadid_t            br_thread,
    input  vptr_t                br_target,
    input  logic                 exc_en,
    input  threadid_t            exc_thread,
    input  vptr_t                exc_pc,
    input  logic                 eret_en,
    input  threadid_t            eret_thread,
    output vptr_t                pc    [N_THREADS],
    output vptr_t                epc   [N_THREADS],
    output logic [N_THREADS-1:0] mode,
    output logic [N_THREADS-1:0] ready,
    output logic [N_THREADS-1:0] epoch
);

    for (genvar t = 0; t < N_THREADS; t++) begin : g_slot
        localparam threadid_t TID = threadid_t'(t);

        thread_pc_slot #(
            .PC_INIT (RESET_PC),
            .PC_TRAP (EXC_VECTOR)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .fetch_en   (fetch_valid && (fetch_thread == TID)),
            .fetch_miss (fetch_miss),
            .refill_en  (refill_done && (refill_thread == TID)),
            .br_en      (br_en && (br_thread == TID)),
            .br_target  (br_target),
            .exc_en     (exc_en && (exc_thread == TID)),
            .exc_pc     (exc_pc),
            .eret_en    (eret_en && (eret_thread == TID)),
            .pc         (pc[t]),
            .epc        (epc[t]),
            .mode       (mode[t]),
            .epoch      (epoch[t]),
            .ready      (ready[t])
        );
    end

endmodule

// File: tb/tb_thread_pc_ctrl.sv
// Scoreboard bench for thread_pc_ctrl: stimulus pushes hand-computed
// expectations after each clock, a monitor drains and compares them on
// the falling edge.
module tb_thread_pc_ctrl;
    import common::*;

    localparam int N = common::n_threads;

    localparam int K_RST    = 0;
    localparam int K_FETCH  = 1;
    localparam int K_MISS   = 2;
    localparam int K_REFILL = 3;
    localparam int K_BR     = 4;
    localparam int K_EXC    = 5;
    localparam int K_ERET   = 6;

    localparam int F_PC    = 0;
    localparam int F_EPC   = 1;
    localparam int F_MODE  = 2;
    localparam int F_READY = 3;
    localparam int F_EPOCH = 4;

    typedef struct {
        string       name;
        int          thr;
        int          field;
        logic [31:0] value;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          fetch_valid;
    threadid_t     fetch_thread;
    logic          fetch_miss;
    logic          refill_done;
    threadid_t     refill_thread;
    logic          br_en;
    threadid_t     br_thread;
    vptr_t         br_target;
    logic          exc_en;
    threadid_t     exc_thread;
    vptr_t         exc_pc;
    logic          eret_en;
    threadid_t     eret_thread;
    vptr_t         pc  [N];
    vptr_t         epc [N];
    logic [N-1:0]  mode;
    logic [N-1:0]  ready;
    logic [N-1:0]  epoch;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    thread_pc_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_valid   (fetch_valid),
        .fetch_thread  (fetch_thread),
        .fetch_miss    (fetch_miss),
        .refill_done   (refill_done),
        .refill_thread (refill_thread),
        .br_en         (br_en),
        .br_thread     (br_thread),
        .br_target     (br_target),
        .exc_en        (exc_en),
        .exc_thread    (exc_thread),
        .exc_pc        (exc_pc),
        .eret_en       (eret_en),
        .eret_thread   (eret_thread),
        .pc            (pc),
        .epc           (epc),
        .mode          (mode),
        .ready         (ready),
        .epoch         (epoch)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] actualOf(input int thr, input int field);
        case (field)
            F_PC:    return pc[thr];
            F_EPC:   return epc[thr];
            F_MODE:  return {31'b0, mode[thr]};
            F_READY: return {31'b0, ready[thr]};
            default: return {31'b0, epoch[thr]};
        endcase
    endfunction

    task automatic checkOutput(input exp_t e);
        logic [31:0] act;
        act = actualOf(e.thr, e.field);
        checks++;
        if (act !== e.value) begin
            errors++;
            $display("[TB] FAIL %s thread %0d: got 0x%08h, want 0x%08h", e.name, e.thr, act, e.value);
        end
    endtask

    // Monitor: compare every pending expectation while outputs are stable
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() != 0) checkOutput(sb.pop_front());
        end
    end

    task automatic clearInputs();
        rst         = 1'b0;
        fetch_valid = 1'b0;
        fetch_miss  = 1'b0;
        refill_done = 1'b0;
        br_en       = 1'b0;
        exc_en      = 1'b0;
        eret_en     = 1'b0;
    endtask

    task automatic applyStimulus(input int kind, input int thr, input vptr_t data);
        case (kind)
            K_RST:    rst = 1'b1;
            K_FETCH:  begin fetch_valid = 1'b1; fetch_thread = threadid_t'(thr); fetch_miss = 1'b0; end
            K_MISS:   begin fetch_valid = 1'b1; fetch_thread = threadid_t'(thr); fetch_miss = 1'b1; end
            K_REFILL: begin refill_done = 1'b1; refill_thread = threadid_t'(thr); end
            K_BR:     begin br_en = 1'b1; br_thread = threadid_t'(thr); br_target = data; end
            K_EXC:    begin exc_en = 1'b1; exc_thread = threadid_t'(thr); exc_pc = data; end
            default:  begin eret_en = 1'b1; eret_thread = threadid_t'(thr); end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clearInputs();
    endtask

    task automatic expectField(input string name, input int thr, input int field, input logic [31:0] value);
        exp_t e;
        e.name  = name;
        e.thr   = thr;
        e.field = field;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic expectThread(input string name, input int thr, input vptr_t p, input vptr_t ep,
                                input logic m, input logic r, input logic ep_bit);
        expectField({name, ".pc"},    thr, F_PC,    p);
        expectField({name, ".epc"},   thr, F_EPC,   ep);
        expectField({name, ".mode"},  thr, F_MODE,  {31'b0, m});
        expectField({name, ".ready"}, thr, F_READY, {31'b0, r});
        expectField({name, ".epoch"}, thr, F_EPOCH, {31'b0, ep_bit});
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, want completion");
        $fatal(1, "[TB] watchdog");
    end

    // Directed stimulus with hand-computed expectations
    initial begin
        fetch_thread  = '0;
        refill_thread = '0;
        br_thread     = '0;
        br_target     = '0;
        exc_thread    = '0;
        exc_pc        = '0;
        eret_thread   = '0;
        clearInputs();
        rst = 1'b1;

        step();
        applyStimulus(K_RST, 0, '0);
        step();
        for (int t = 0; t < N; t++) expectThread("reset", t, 32'h1000, 32'h0, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(K_FETCH, 0, '0);
            step();
        end
        expectField("seq3.pc", 0, F_PC, 32'h100C);
        for (int t = 1; t < N; t++) expectField("idle.pc", t, F_PC, 32'h1000);

        applyStimulus(K_FETCH, 1, '0);
        step();
        expectField("t1_first.pc", 1, F_PC, 32'h1004);

        applyStimulus(K_MISS, 1, '0);
        step();
        expectField("miss.ready", 1, F_READY, 32'h0);
        expectField("miss.pc", 1, F_PC, 32'h1004);

        applyStimulus(K_FETCH, 1, '0);
        step();
        expectField("wait_fetch.pc", 1, F_PC, 32'h1004);
        expectField("wait_fetch.ready", 1, F_READY, 32'h0);

        applyStimulus(K_REFILL, 1, '0);
        step();
        expectField("refill.ready", 1, F_READY, 32'h1);
        expectField("refill.pc", 1, F_PC, 32'h1004);

        applyStimulus(K_FETCH, 1, '0);
        step();
        expectThread("refetch", 1, 32'h1008, 32'h0, 1'b1, 1'b1, 1'b0);

        applyStimulus(K_EXC, 2, 32'h1010);
        applyStimulus(K_BR, 2, 32'h3000);
        applyStimulus(K_FETCH, 2, '0);
        step();
        expectThread("exc_prio", 2, 32'h2000, 32'h1010, 1'b1, 1'b1, 1'b1);

        applyStimulus(K_BR, 0, 32'h6000);
        applyStimulus(K_EXC, 1, 32'h1008);
        step();
        expectThread("br_t0", 0, 32'h6000, 32'h0, 1'b1, 1'b1, 1'b1);
        expectThread("exc_t1", 1, 32'h2000, 32'h1008, 1'b1, 1'b1, 1'b1);

        applyStimulus(K_ERET, 2, '0);
        step();
        expectThread("eret", 2, 32'h1010, 32'h1010, 1'b0, 1'b1, 1'b0);

        applyStimulus(K_MISS, 3, '0);
        step();
        expectField("t3_miss.ready", 3, F_READY, 32'h0);

        applyStimulus(K_BR, 3, 32'h4003);
        step();
        expectThread("br_wait", 3, 32'h4000, 32'h0, 1'b1, 1'b1, 1'b1);

        applyStimulus(K_REFILL, 3, '0);
        step();
        expectThread("late_refill", 3, 32'h4000, 32'h0, 1'b1, 1'b1, 1'b1);

        applyStimulus(K_FETCH, 3, '0);
        step();
        expectField("after_late.pc", 3, F_PC, 32'h4004);

        applyStimulus(K_BR, 0, 32'hFFFF_FFFC);
        step();
        expectField("br_top.pc", 0, F_PC, 32'hFFFF_FFFC);
        expectField("br_top.epoch", 0, F_EPOCH, 32'h0);

        applyStimulus(K_FETCH, 0, '0);
        step();
        expectField("wrap.pc", 0, F_PC, 32'h0000_0000);

        applyStimulus(K_RST, 0, '0);
        applyStimulus(K_BR, 0, 32'h5000);
        step();
        for (int t = 0; t < N; t++) expectThread("rst_br", t, 32'h1000, 32'h0, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending expectations, want 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
